if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch-to-decode decoupling queue: a DEPTH-entry circular buffer of fetch packets (PC, instruction, predicted-taken) between IF and ID with valid/ready handshakes on both sides. It replaces the single-entry IF/ID register, which can only hold or bubble. It absorbs decode back-pressure without stalling fetch until full, supports single-cycle flush, and flags the post-flush bubble to decode.

## Interface
- XLEN, 32, PC and instruction width
- DEPTH, 4, entry count; power of two, >= 2
- PW, $clog2(DEPTH), pointer index width (derived, not overridden)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_flush  in  1  drop all entries and the same-cycle push
- i_valid  in  1  upstream packet valid
- o_ready  out  1  queue can accept a packet
- i_pc  in  XLEN  fetch PC
- i_instr  in  XLEN  fetched instruction
- i_pred_taken  in  1  IF predicted taken
- o_valid  out  1  head packet valid
- i_ready  in  1  decode accepts head packet
- o_pc  out  XLEN  head PC
- o_instr  out  XLEN  head instruction
- o_pred_taken  out  1  head prediction bit
- o_bubble  out  1  queue empty because of a flush
- o_count  out  PW+1  occupancy, 0..DEPTH
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0

## Operation
- Write/read pointers are PW+1 bits. Index = low PW bits; full when indices match and MSBs differ. Pointers wrap naturally at 2*DEPTH.
- push = i_valid & o_ready & ~i_flush. pop = o_valid & i_ready & ~i_flush.
- o_ready = ~o_full & ~i_reset. No combinational dependence on i_ready: a full queue refuses a push even in a popping cycle.
- Simultaneous push and pop: both pointers advance and o_count is unchanged. Legal at any non-full occupancy.
- o_valid = ~o_empty. o_pc, o_instr and o_pred_taken show the head entry when valid and are forced to 0 when empty.
- Flush has priority over push and pop. The next edge clears both pointers and o_count. The incoming packet is discarded and no pop is signalled.
- o_bubble is registered. It is set by a flush, cleared by the first push after it, and otherwise holds.
- Reset, at any time including mid-operation: asynchronously clears the pointers, o_count and o_bubble. Outputs: o_valid 0, o_ready 0 while asserted then 1, o_empty 1, o_full 0, o_count 0, data outputs 0. Storage contents are don't-care.

## Timing
- Push at edge N: the packet is visible at the head from N+1 when the queue was empty. Otherwise it is visible after all older entries pop.
- Pop at edge N: the next entry, or empty, is presented after edge N.
- Flush asserted in cycle N: o_valid = 0, o_count = 0 and o_bubble = 1 after edge N. o_ready = 1 from the same point.
- o_full and o_empty are registered-state decodes with no input-to-output paths, except under IFQ_BYPASS_EN.

## Configuration
- IFQ_BYPASS_EN defined: when the queue is empty, i_valid = 1 and i_flush = 0:
  - o_valid = 1 and the head outputs equal the inputs combinationally in the same cycle.
  - If i_ready = 1, the packet is consumed without being written and o_count stays 0.
  - If i_ready = 0, the packet is written normally.
  - Zero-cycle latency.
- IFQ_BYPASS_EN undefined: fully registered, one-cycle minimum latency as described above.

## Structure
- Package if_id_pkg:
  - typedef struct packed fetch_pkt_t { logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; logic pred_taken; }
  - localparam IFQ_DEFAULT_DEPTH = 4.
- Sub-module ifq_mem: DEPTH x fetch_pkt_t register array with one synchronous write port and one asynchronous read port, no reset.
- Pointers, count, flags and the bypass mux live in if_id_queue.

## Test plan
- Reset, then push PCs 0x100, 0x104, 0x108 with i_ready = 0 -> o_count = 3 and o_pc = 0x100. Raise i_ready -> PCs pop in order, one per cycle, then o_empty = 1.
- DEPTH = 4: push 5 packets with i_ready = 0 -> o_full = 1 and o_ready = 0 after the 4th. The 5th is held upstream and accepted after one pop.
- Continuous push and pop across more than 2*DEPTH packets -> pointers wrap, o_count stays 1, and the PC sequence is intact.
- Queue at count 3 with i_flush and i_valid both high -> o_count = 0, o_valid = 0 and o_bubble = 1 next cycle. The next push clears o_bubble.
- Assert i_reset asynchronously mid-stream, between edges -> all outputs reach their reset values immediately. The first push after release appears with o_count = 1.
- IFQ_BYPASS_EN, empty queue, i_valid = 1, i_ready = 1, i_pc = 0x200 -> o_valid = 1 and o_pc = 0x200 in the same cycle, with o_count remaining 0.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types for the IF/ID decoupling queue.
//   fetch_pkt_t       : one fetch packet (PC, instruction, predicted-taken)
//   IFQ_DEFAULT_DEPTH : default queue depth
//   IFQ_DEFAULT_XLEN  : default PC/instruction width, matches fetch_pkt_t
package if_id_pkg;

  localparam int unsigned IFQ_DEFAULT_DEPTH = 4;
  localparam int unsigned IFQ_DEFAULT_XLEN  = 32;

  typedef struct packed {
    logic [IFQ_DEFAULT_XLEN-1:0] pc;
    logic [IFQ_DEFAULT_XLEN-1:0] instr;
    logic                        pred_taken;
  } fetch_pkt_t;

endpackage

// File: rtl/ifq_mem.sv
// Storage array for the IF/ID queue: DEPTH packets, one synchronous write
// port and one asynchronous read port. No reset; contents are only
// meaningful between the queue pointers.
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : packet to store
//   i_raddr : read index
//   o_rdata : packet at i_raddr (combinational)
module ifq_mem
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH,
  parameter int unsigned PW    = $clog2(DEPTH),
  parameter type         pkt_t = fetch_pkt_t
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  pkt_t          i_wdata,
  input  logic [PW-1:0] i_raddr,
  output pkt_t          o_rdata
);

  pkt_t mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: DEPTH-entry circular buffer of fetch
// packets with valid/ready handshakes on both sides, single-cycle flush and
// a registered post-flush bubble flag.
// Optional feature: define IFQ_BYPASS_EN for a zero-latency path from the
// inputs to the head outputs while the queue is empty.
//   i_clk, i_reset              : clock, async active-high reset
//   i_flush                     : drop all entries and the same-cycle push
//   i_valid/o_ready             : upstream handshake
//   i_pc/i_instr/i_pred_taken   : incoming packet
//   o_valid/i_ready             : downstream handshake
//   o_pc/o_instr/o_pred_taken   : head packet, 0 when empty
//   o_bubble                    : empty because of a flush
//   o_count/o_full/o_empty      : occupancy and its decodes
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned XLEN  = IFQ_DEFAULT_XLEN,
  parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  input  logic            i_pred_taken,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic            o_pred_taken,
  output logic            o_bubble,
  output logic [PW:0]     o_count,
  output logic            o_full,
  output logic            o_empty
);

  // Same layout as fetch_pkt_t, but sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } pkt_t;

  localparam logic [PW:0] PtrOne = 1;

  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        bubble_q, bubble_d;
  logic        full, empty, bypass, accept, push, pop;
  pkt_t        in_pkt, rd_pkt, head_pkt;

  // Extra MSB distinguishes full from empty when the indices coincide.
  assign full  = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);
  assign empty = (wptr_q == rptr_q);

  assign in_pkt = '{pc: i_pc, instr: i_instr, pred_taken: i_pred_taken};

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & i_valid & ~i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign o_ready = ~full & ~i_reset;
  assign accept  = i_valid & o_ready & ~i_flush;
  // A bypassed packet consumed the same cycle is never written.
  assign push    = accept & ~(bypass & i_ready);
  assign pop     = ~empty & i_ready & ~i_flush;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    bubble_d = bubble_q;
    if (i_flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      bubble_d = 1'b1;
    end else begin
      if (push) wptr_d = wptr_q + PtrOne;
      if (pop)  rptr_d = rptr_q + PtrOne;
      if (accept) bubble_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      bubble_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      bubble_q <= bubble_d;
    end
  end

  ifq_mem #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .pkt_t (pkt_t)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wptr_q[PW-1:0]),
    .i_wdata (in_pkt),
    .i_raddr (rptr_q[PW-1:0]),
    .o_rdata (rd_pkt)
  );

  always_comb begin
    head_pkt = '0;
    if (bypass) begin
      head_pkt = in_pkt;
    end else if (!empty) begin
      head_pkt = rd_pkt;
    end
  end

  assign o_valid      = ~empty | bypass;
  assign o_pc         = head_pkt.pc;
  assign o_instr      = head_pkt.instr;
  assign o_pred_taken = head_pkt.pred_taken;
  assign o_bubble     = bubble_q;
  assign o_count      = wptr_q - rptr_q;
  assign o_full       = full;
  assign o_empty      = empty;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (default build). A reference model
// holds the expected queue contents as a SystemVerilog queue; a separate
// monitor compares every DUT output against it on the falling edge.
module tb_if_id_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } exp_t;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_flush = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [XLEN-1:0] i_pc = '0;
  logic [XLEN-1:0] i_instr = '0;
  logic            i_pred_taken = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_instr;
  logic            o_pred_taken;
  logic            o_bubble;
  logic [PW:0]     o_count;
  logic            o_full;
  logic            o_empty;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic m_bubble = 1'b0;

  if_id_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_pc         (i_pc),
    .i_instr      (i_instr),
    .i_pred_taken (i_pred_taken),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .o_pred_taken (o_pred_taken),
    .o_bubble     (o_bubble),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: updated on every active edge (or reset) from the bench's
  // own inputs; acceptance is decided by model occupancy, not by o_ready.
  initial begin
    forever begin
      @(posedge i_clk or posedge i_reset);
      if (i_reset) begin
        exp_q.delete();
        m_bubble = 1'b0;
      end else if (i_flush) begin
        exp_q.delete();
        m_bubble = 1'b1;
      end else begin
        automatic bit do_pop  = (exp_q.size() != 0) && i_ready;
        automatic bit do_push = i_valid && (exp_q.size() < DEPTH);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          exp_q.push_back('{pc: i_pc, instr: i_instr, pt: i_pred_taken});
          m_bubble = 1'b0;
        end
      end
    end
  end

  // Monitor: compares outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        automatic int n = exp_q.size();
        chk("count", 64'(o_count), 64'(n));
        chk("valid", 64'(o_valid), 64'(n != 0));
        chk("empty", 64'(o_empty), 64'(n == 0));
        chk("full", 64'(o_full), 64'(n == DEPTH));
        chk("ready", 64'(o_ready), 64'(n < DEPTH));
        chk("bubble", 64'(o_bubble), 64'(m_bubble));
        if (n != 0) begin
          chk("head_pc", 64'(o_pc), 64'(exp_q[0].pc));
          chk("head_instr", 64'(o_instr), 64'(exp_q[0].instr));
          chk("head_pt", 64'(o_pred_taken), 64'(exp_q[0].pt));
        end else begin
          chk("empty_data", {o_pc, o_instr} | 64'(o_pred_taken), 64'd0);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    @(posedge i_clk);
    #1;
    i_valid      = v;
    i_pc         = pc;
    i_instr      = $urandom;
    i_pred_taken = 1'($urandom_range(0, 1));
    i_ready      = rdy;
    i_flush      = fl;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_ready"}, 64'(o_ready), 64'd0);
    chk({tag, "_empty"}, 64'(o_empty), 64'd1);
    chk({tag, "_full"}, 64'(o_full), 64'd0);
    chk({tag, "_count"}, 64'(o_count), 64'd0);
    chk({tag, "_bubble"}, 64'(o_bubble), 64'd0);
    chk({tag, "_data"}, {o_pc, o_instr} | 64'(o_pred_taken), 64'd0);
  endtask

  initial begin
    logic [31:0] pc;
    // Power-on reset
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_outputs("por");
    i_reset = 1'b0;

    // Three pushes under back-pressure, then in-order drain
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h108, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("fill3_count", 64'(o_count), 64'd3);
    chk("fill3_pc", 64'(o_pc), 64'h100);
    drain();
    #3;
    chk("drain_empty", 64'(o_empty), 64'd1);

    // Full: fifth packet held upstream until one pop
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h210, 1'b0, 1'b0);
    #3;
    chk("full_flag", 64'(o_full), 64'd1);
    chk("full_ready", 64'(o_ready), 64'd0);
    step(1'b1, 32'h210, 1'b1, 1'b0);
    step(1'b1, 32'h210, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("refill_count", 64'(o_count), 64'd4);
    chk("refill_head", 64'(o_pc), 64'h204);
    drain();

    // Streaming across pointer wrap: occupancy stays at one
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0);
      if (i >= 1) begin
        #3;
        chk("stream_count", 64'(o_count), 64'd1);
        chk("stream_pc", 64'(o_pc), 64'(32'h300 + 32'(4 * (i - 1))));
      end
    end
    drain();

    // Flush with a concurrent push, then bubble clear on next push
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h40c, 1'b0, 1'b1);
    #3;
    chk("preflush_count", 64'(o_count), 64'd3);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_bubble", 64'(o_bubble), 64'd1);
    chk("flush_ready", 64'(o_ready), 64'd1);
    step(1'b1, 32'h500, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("bubble_clear", 64'(o_bubble), 64'd0);
    chk("post_flush_pc", 64'(o_pc), 64'h500);
    drain();

    // Randomised traffic
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
      pc += 32'd4;
    end

    // Asynchronous reset between edges, mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0);
    #2;
    i_reset = 1'b1;
    #1;
    chk_reset_outputs("async");
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rst_hold_ready", 64'(o_ready), 64'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
    chk("rst_rel_ready", 64'(o_ready), 64'd1);
    step(1'b1, 32'h600, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("after_rst_count", 64'(o_count), 64'd1);
    chk("after_rst_pc", 64'(o_pc), 64'h600);
    drain();

    repeat (2) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
